// File: rtl/i2c_bus_arbiter_pkg.sv
// Purpose: shared types and field widths for the I2C engine arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_arb_pkg;

    localparam int ADDR_W = 7;   // I2C slave address
    localparam int REG_W  = 16;  // device register address
    localparam int NB_W   = 17;  // remaining-bytes count
    localparam int DATA_W = 8;   // byte lane

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOCK  = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_GUARD = 3'd4
    } state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Purpose: bundles requester-side and engine-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: engine readiness is returned per requester through rsp_ready.
// Modports: slave = arbiter view, master = requesters + engine (bench) view.
interface i2c_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    import i2c_arb_pkg::*;

    // requester side
    logic [N_REQ-1:0]        req;
    logic [ADDR_W*N_REQ-1:0] req_slave_addr;
    logic [REG_W*N_REQ-1:0]  req_reg_addr;
    logic [N_REQ-1:0]        req_is_read;
    logic [NB_W*N_REQ-1:0]   req_nb_bytes;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_data;
    logic [N_REQ-1:0]        rsp_timeout;

    // engine side
    logic                    i2c_start;
    logic [ADDR_W-1:0]       i2c_slave_adress;
    logic [REG_W-1:0]        i2c_register_address;
    logic                    i2c_is_read;
    logic [NB_W-1:0]         i2c_nb_of_bytes;
    logic [DATA_W-1:0]       i2c_data_in;
    logic                    i2c_reset;
    logic                    i2c_ready;
    logic [DATA_W-1:0]       i2c_data_out;

    modport slave (
        input  req, req_slave_addr, req_reg_addr, req_is_read, req_nb_bytes, req_wdata,
        input  i2c_ready, i2c_data_out,
        output grant, rsp_ready, rsp_data, rsp_timeout,
        output i2c_start, i2c_slave_adress, i2c_register_address, i2c_is_read,
        output i2c_nb_of_bytes, i2c_data_in, i2c_reset
    );

    modport master (
        output req, req_slave_addr, req_reg_addr, req_is_read, req_nb_bytes, req_wdata,
        output i2c_ready, i2c_data_out,
        input  grant, rsp_ready, rsp_data, rsp_timeout,
        input  i2c_start, i2c_slave_adress, i2c_register_address, i2c_is_read,
        input  i2c_nb_of_bytes, i2c_data_in, i2c_reset
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker; searches upward from last+1 with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid=0 when no request is set.
// Ports: req (level requests), last (previous winner) -> valid, idx, onehot.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        int cand;
        cand   = 0;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // k runs 1..N_REQ so the previous winner is examined last
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = IDX_W'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Purpose: shares one I2C byte engine between N_REQ requesters with round-robin grant.
// Latency: grant 1 cycle after request seen in IDLE, i2c_start 2 cycles after.
// Backpressure: losers wait on level req; engine ready is routed only to the granted slot.
// Ports: clock, reset (sync, active-high), bus (slave modport: requester fields in,
//        grant/rsp_* out, muxed engine fields out, i2c_ready/i2c_data_out in).
module i2c_bus_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GUARD_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TO_W           = 24
) (
    input  logic             clock,
    input  logic             reset,
    i2c_bus_arbiter_if.slave bus
);
    import i2c_arb_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] last;       // index of the current / most recent grant
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] timeout_q;
    logic             start_q;
    logic             abort_q;
    logic [TO_W-1:0]  cnt;        // shared: timeout count in BUSY, gap count in GUARD

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .last   (last),
        .valid  (pick_vld),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            last      <= IDX_W'(N_REQ - 1);
            grant_q   <= '0;
            timeout_q <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_onehot;
                        last    <= pick_idx;
                        state   <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // fields have been stable for a cycle; start lands next cycle
                    start_q <= 1'b1;
                    state   <= ST_START;
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    // timeout checked first so a simultaneous release still aborts the engine
                    if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_q   <= 1'b1;
                        timeout_q <= grant_q;
                        grant_q   <= '0;
                        cnt       <= '0;
                        state     <= ST_GUARD;
                    end else if (!bus.req[last]) begin
                        grant_q <= '0;
                        cnt     <= '0;
                        state   <= ST_GUARD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt == TO_W'(GUARD_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // field muxes driven from the registered index, zeroed when nothing is granted
    always_comb begin
        bus.i2c_slave_adress     = '0;
        bus.i2c_register_address = '0;
        bus.i2c_is_read          = 1'b0;
        bus.i2c_nb_of_bytes      = '0;
        bus.i2c_data_in          = '0;
        if (|grant_q) begin
            bus.i2c_slave_adress     = bus.req_slave_addr[int'(last)*ADDR_W +: ADDR_W];
            bus.i2c_register_address = bus.req_reg_addr[int'(last)*REG_W +: REG_W];
            bus.i2c_is_read          = bus.req_is_read[last];
            bus.i2c_nb_of_bytes      = bus.req_nb_bytes[int'(last)*NB_W +: NB_W];
            bus.i2c_data_in          = bus.req_wdata[int'(last)*DATA_W +: DATA_W];
        end
    end

    assign bus.grant       = grant_q;
    assign bus.rsp_ready   = grant_q & {N_REQ{bus.i2c_ready}};
    assign bus.rsp_data    = bus.i2c_data_out;
    assign bus.rsp_timeout = timeout_q;
    assign bus.i2c_start   = start_q;
    assign bus.i2c_reset   = reset | abort_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Purpose: directed self-checking bench for i2c_bus_arbiter (4 requesters, timeout 100).
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    i2c_bus_arbiter_if #(.N_REQ(N)) bus();

    i2c_bus_arbiter #(
        .N_REQ          (N),
        .GUARD_CYCLES   (64),
        .TIMEOUT_CYCLES (100),
        .TO_W           (24)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bounded wait for any grant, then compare it
    task automatic wait_grant(input string tag, input logic [N-1:0] exp);
        int n;
        n = 0;
        while (bus.grant == '0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.grant), 32'(exp));
    endtask

    initial begin
        logic [N-1:0] exp_g;
        bus.req          = '0;
        bus.req_is_read  = 4'b0100;
        bus.i2c_ready    = 1'b0;
        bus.i2c_data_out = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_slave_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(16 + i);
            bus.req_reg_addr[i*REG_W +: REG_W]     = REG_W'(16'hA000 + i);
            bus.req_nb_bytes[i*NB_W +: NB_W]       = NB_W'(i + 1);
            bus.req_wdata[i*DATA_W +: DATA_W]      = DATA_W'(8'hC0 + i);
        end

        // reset values
        tick(2);
        chk("rst_grant",     32'(bus.grant), 0);
        chk("rst_start",     32'(bus.i2c_start), 0);
        chk("rst_timeout",   32'(bus.rsp_timeout), 0);
        chk("rst_i2c_reset", 32'(bus.i2c_reset), 1);
        chk("rst_mux_addr",  32'(bus.i2c_slave_adress), 0);
        reset = 1'b0;
        tick();
        chk("rst_release_i2c_reset", 32'(bus.i2c_reset), 0);

        // single write transaction on slot 0
        bus.req = 4'b0001;
        tick();
        chk("t1_grant",      32'(bus.grant), 32'h1);
        chk("t1_start_lock", 32'(bus.i2c_start), 0);
        chk("t1_mux_addr",   32'(bus.i2c_slave_adress), 32'h10);
        chk("t1_mux_reg",    32'(bus.i2c_register_address), 32'hA000);
        chk("t1_mux_rd",     32'(bus.i2c_is_read), 0);
        chk("t1_mux_nb",     32'(bus.i2c_nb_of_bytes), 1);
        chk("t1_mux_wdata",  32'(bus.i2c_data_in), 32'hC0);
        tick();
        chk("t1_start",      32'(bus.i2c_start), 1);
        tick();
        chk("t1_start_off",  32'(bus.i2c_start), 0);
        bus.req = '0;
        tick();
        chk("t1_release",    32'(bus.grant), 0);
        // re-request during guard: exactly 64 guard cycles, then one IDLE cycle
        bus.req = 4'b0001;
        tick(64);
        chk("t1_guard_hold", 32'(bus.grant), 0);
        tick();
        chk("t1_regrant",    32'(bus.grant), 32'h1);
        tick(2);
        bus.req = '0;
        tick();

        // all slots requesting from reset (last=3): order 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            wait_grant("t2_order", exp_g);
            if (k == 2) begin
                chk("t2_mux_addr", 32'(bus.i2c_slave_adress), 32'h12);
                chk("t2_mux_nb",   32'(bus.i2c_nb_of_bytes), 3);
                chk("t2_mux_rd",   32'(bus.i2c_is_read), 1);
            end
            tick(2);
            bus.req = bus.req & ~exp_g;
            tick();
            chk("t2_release", 32'(bus.grant), 0);
            bus.req = 4'b1111;
        end
        bus.req = '0;

        // no preemption: slot 2 busy while slot 0 asks
        bus.req = 4'b0100;
        wait_grant("t3_grant2", 4'b0100);
        tick(2);
        bus.req = 4'b0101;
        tick(10);
        chk("t3_no_preempt", 32'(bus.grant), 32'h4);
        bus.req = 4'b0001;
        tick();
        chk("t3_release", 32'(bus.grant), 0);
        wait_grant("t3_grant0", 4'b0001);
        tick(2);
        bus.req = '0;
        tick();

        // engine ready routed to slot 3 only
        bus.req = 4'b1000;
        wait_grant("t4_grant3", 4'b1000);
        tick(2);
        bus.i2c_data_out = 8'h5A;
        bus.i2c_ready    = 1'b1;
        #1;
        chk("t4_rsp_ready", 32'(bus.rsp_ready), 32'h8);
        chk("t4_rsp_data",  32'(bus.rsp_data), 32'h5A);
        bus.i2c_ready = 1'b0;
        #1;
        chk("t4_rsp_ready_off", 32'(bus.rsp_ready), 0);
        bus.req = '0;
        tick();
        bus.i2c_ready = 1'b1;
        #1;
        chk("t4_guard_rdy", 32'(bus.rsp_ready), 0);
        bus.i2c_ready = 1'b0;

        // timeout on slot 1; release lands on the same cycle and timeout still wins
        bus.req = 4'b0010;
        wait_grant("t5_grant1", 4'b0010);
        tick(101);
        chk("t5_pre_grant", 32'(bus.grant), 32'h2);
        chk("t5_pre_reset", 32'(bus.i2c_reset), 0);
        chk("t5_pre_to",    32'(bus.rsp_timeout), 0);
        bus.req = '0;
        tick();
        chk("t5_i2c_reset", 32'(bus.i2c_reset), 1);
        chk("t5_rsp_to",    32'(bus.rsp_timeout), 32'h2);
        chk("t5_grant",     32'(bus.grant), 0);
        tick();
        chk("t5_reset_off", 32'(bus.i2c_reset), 0);
        chk("t5_to_off",    32'(bus.rsp_timeout), 0);

        // reset while BUSY
        bus.req = 4'b0001;
        wait_grant("t6_grant0", 4'b0001);
        tick(2);
        reset = 1'b1;
        #1;
        chk("t6_i2c_reset", 32'(bus.i2c_reset), 1);
        tick();
        chk("t6_grant", 32'(bus.grant), 0);
        chk("t6_start", 32'(bus.i2c_start), 0);
        chk("t6_to",    32'(bus.rsp_timeout), 0);
        reset = 1'b0;
        tick();
        chk("t6_idle_grant", 32'(bus.grant), 32'h1);
        tick();
        chk("t6_restart", 32'(bus.i2c_start), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
